ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the dual-port data RAM (two address ports, one write path) between the ODE solver core (requester 0) and the interpolation module (requester 1).
- Round-robin grant with bounded hold and a one-cycle turnaround between owners.
- Routes addresses and write data to the RAM, and returns read data to the current owner with a valid pulse.
- Sits between both datapath blocks and the RAM.

Parameters:
WORD_SIZE, 16, RAM data width
ADDRESS_WIDTH, 16, RAM address width
MAX_HOLD, 8, accesses an owner may make while the other requester waits; 0 disables preemption
CNT_W, 4, hold counter width; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req0  in  1  requester 0 wants or holds the RAM
wr0  in  1  requester 0 access is a write (qualified by req0&gnt0)
add1_0  in  ADDRESS_WIDTH  requester 0 port-1 address (read/write address)
add2_0  in  ADDRESS_WIDTH  requester 0 port-2 address (read only)
wdata0  in  WORD_SIZE  requester 0 write data
gnt0  out  1  requester 0 owns the RAM
rvalid0  out  1  read data valid for requester 0
req1, wr1, add1_1, add2_1, wdata1, gnt1, rvalid1: same widths and meaning for requester 1
rdata1  out  WORD_SIZE  port-1 read data (ram_data1 passthrough)
rdata2  out  WORD_SIZE  port-2 read data (ram_data2 passthrough)
ram_add1  out  ADDRESS_WIDTH  RAM port-1 address
ram_add2  out  ADDRESS_WIDTH  RAM port-2 address
ram_wdata  out  WORD_SIZE  RAM write data
ram_we  out  1  RAM write enable, port 1
ram_data1  in  WORD_SIZE  RAM port-1 read data, 1-cycle synchronous latency
ram_data2  in  WORD_SIZE  RAM port-2 read data, 1-cycle synchronous latency

Behaviour:
- States are IDLE, OWN0, OWN1 and TURN. gnt0 = (state==OWN0); gnt1 = (state==OWN1). Grants are registered.
- Reset (rst low, async): state=IDLE, last_owner=1 (requester 0 wins the first tie), hold_cnt=0, gnt0=gnt1=0, rvalid0=rvalid1=0. Combinational outputs: ram_we=0, ram_add1=ram_add2=0, ram_wdata=0.
- IDLE/TURN arbitration at the clock edge:
  - Only reqX high: go to OWNX.
  - Both high: go to OWN(~last_owner).
  - Neither high: go to IDLE.
  - Grant latency from req in IDLE is 1 cycle (gnt high the cycle after req is first sampled).
- Access: every cycle in OWNX with reqX=1 is one access.
  - ram_add1=add1_X, ram_add2=add2_X, ram_wdata=wdata_X, ram_we=wrX.
  - If state is not OWNX or reqX=0: ram_we=0, addresses=0.
- Reads: for a read access (wrX=0), rvalidX=1 on the next cycle, and rdata1/rdata2 hold the RAM output then. rvalid is a registered 1-cycle pulse per access, so back-to-back reads give continuous rvalid.
- hold_cnt: cleared on entry to OWNX; increments per access, saturating at MAX_HOLD.
- OWNX exit:
  - reqX=0 → TURN. last_owner=X.
  - MAX_HOLD!=0, the access this cycle is number MAX_HOLD (hold_cnt==MAX_HOLD-1 with reqX=1), and the other req is high → TURN after this access (preemption). last_owner=X.
  - Otherwise stay.
  - If the other requester is idle, the owner keeps the grant indefinitely; hold_cnt saturates.
- TURN: lasts exactly 1 cycle with no grant and no RAM access. It delivers any pending rvalid of the previous owner, then arbitrates as IDLE. The preempted requester, if still requesting, is re-granted after the other finishes (round-robin).
- A requester raising wr or addresses without a grant has no effect. Requesters hold req high until gnt is seen.
- Reset mid-operation: outputs go to reset values immediately and a pending rvalid is dropped. The in-flight RAM write of that cycle is not guaranteed.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10, TURN=2'b11) and the requester ids REQ_SOLVER=0, REQ_INTERP=1.
- One sub-module, arb_hold_counter: saturating CNT_W-bit counter with clear/increment and a terminal flag at MAX_HOLD-1. The datapath muxes reuse the existing mux_2_1.

Test Plan:
- Reset, then req1=1 only at cycle 2 → gnt1=1 at cycle 3. Read add1_1=0x0004, add2_1=0x0201 → ram_add1=0x0004, ram_add2=0x0201 at cycle 3; rvalid1=1 at cycle 4 with rdata = RAM contents.
- req0 and req1 rise in the same cycle after reset → gnt0 first. Drop req0 → 1 TURN cycle, then gnt1. Both request again after → gnt0 (last_owner=1).
- MAX_HOLD=8: requester 0 streams writes (wr0=1, wdata0=0x0080 onward) while req1 stays high → exactly 8 ram_we pulses, 1 TURN cycle, then gnt1. gnt0 returns after req1 drops.
- MAX_HOLD=8, req1 low throughout: requester 0 performs 20 accesses → gnt0 never drops, hold_cnt saturates at 8.
- Read in the last OWN0 cycle before release → rvalid0=1 during TURN, rvalid1 stays 0, and the data matches the address.
- Assert rst low while gnt1=1 and a read is in flight → gnt1, rvalid1 and ram_we go to 0 immediately. After rst goes high, req0 is granted with the normal 1-cycle latency.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter: FSM state encoding,
// requester ids and the idle/turnaround arbitration rule.
package ram_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;
    localparam logic [1:0] ST_TURN = 2'b11;

    typedef enum logic {
        REQ_SOLVER = 1'b0,
        REQ_INTERP = 1'b1
    } req_id_t;

    // Pick the next owner from IDLE or TURN; a tie goes to whoever did not own last.
    function automatic logic [1:0] arbitrate(input logic r0, input logic r1, input req_id_t last);
        logic [1:0] nxt;
        if (r0 && r1) begin
            nxt = (last == REQ_INTERP) ? ST_OWN0 : ST_OWN1;
        end else if (r0) begin
            nxt = ST_OWN0;
        end else if (r1) begin
            nxt = ST_OWN1;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester channels and the RAM-side bus around the
// arbiter. The arbiter uses the slave view; requesters and RAM use master.
interface ram_port_arbiter_if #(
    parameter int WORD_SIZE     = 16,
    parameter int ADDRESS_WIDTH = 16
);
    logic                     req0;
    logic                     wr0;
    logic [ADDRESS_WIDTH-1:0] add1_0;
    logic [ADDRESS_WIDTH-1:0] add2_0;
    logic [WORD_SIZE-1:0]     wdata0;
    logic                     gnt0;
    logic                     rvalid0;

    logic                     req1;
    logic                     wr1;
    logic [ADDRESS_WIDTH-1:0] add1_1;
    logic [ADDRESS_WIDTH-1:0] add2_1;
    logic [WORD_SIZE-1:0]     wdata1;
    logic                     gnt1;
    logic                     rvalid1;

    logic [WORD_SIZE-1:0]     rdata1;
    logic [WORD_SIZE-1:0]     rdata2;

    logic [ADDRESS_WIDTH-1:0] ram_add1;
    logic [ADDRESS_WIDTH-1:0] ram_add2;
    logic [WORD_SIZE-1:0]     ram_wdata;
    logic                     ram_we;
    logic [WORD_SIZE-1:0]     ram_data1;
    logic [WORD_SIZE-1:0]     ram_data2;

    modport slave (
        input  req0, wr0, add1_0, add2_0, wdata0,
        input  req1, wr1, add1_1, add2_1, wdata1,
        input  ram_data1, ram_data2,
        output gnt0, rvalid0, gnt1, rvalid1,
        output rdata1, rdata2,
        output ram_add1, ram_add2, ram_wdata, ram_we
    );

    modport master (
        output req0, wr0, add1_0, add2_0, wdata0,
        output req1, wr1, add1_1, add2_1, wdata1,
        output ram_data1, ram_data2,
        input  gnt0, rvalid0, gnt1, rvalid1,
        input  rdata1, rdata2,
        input  ram_add1, ram_add2, ram_wdata, ram_we
    );

endinterface

// File: rtl/mux_2_1.sv
// Generic two-input multiplexer used for the arbiter's datapath steering.
module mux_2_1 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/ram_port_arbiter_hold_counter.sv
// Counts the accesses made by the current owner. Saturates at MAX_HOLD so a
// lone owner never wraps, and flags the access that must be its last one
// when the other requester is waiting.
module arb_hold_counter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic terminal
);

    localparam logic [CNT_W-1:0] SAT_VAL  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] TERM_VAL = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt;

    // Clear while nobody owns the RAM, otherwise count accesses up to saturation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != SAT_VAL)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign terminal = (MAX_HOLD != 0) && (cnt == TERM_VAL);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the dual-port data RAM between the ODE solver core (requester 0)
// and the interpolation module (requester 1): round-robin ownership with a
// bounded hold, a one-cycle turnaround between owners, address/write-data
// steering and a registered read-valid pulse back to the owner.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE     = 16,
    parameter int ADDRESS_WIDTH = 16,
    parameter int MAX_HOLD      = 8,
    parameter int CNT_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_port_arbiter_if.slave     bus
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    req_id_t    last_owner;
    req_id_t    last_owner_nxt;

    logic own0;
    logic own1;
    logic acc0;
    logic acc1;
    logic access;
    logic hold_term;
    logic rvalid0_q;
    logic rvalid1_q;

    logic [ADDRESS_WIDTH-1:0] sel_add1;
    logic [ADDRESS_WIDTH-1:0] sel_add2;
    logic [WORD_SIZE-1:0]     sel_wdata;
    logic                     sel_wr;

    assign own0   = (state == ST_OWN0);
    assign own1   = (state == ST_OWN1);
    assign acc0   = own0 && bus.req0;
    assign acc1   = own1 && bus.req1;
    assign access = acc0 || acc1;

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .clr      (!(own0 || own1)),
        .inc      (access),
        .terminal (hold_term)
    );

    // Owner transitions: arbitrate when free, release on drop or when the hold budget runs out under contention.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            ST_IDLE, ST_TURN: begin
                state_nxt = arbitrate(bus.req0, bus.req1, last_owner);
            end
            ST_OWN0: begin
                if (!bus.req0 || (hold_term && bus.req1)) begin
                    state_nxt      = ST_TURN;
                    last_owner_nxt = REQ_SOLVER;
                end
            end
            ST_OWN1: begin
                if (!bus.req1 || (hold_term && bus.req0)) begin
                    state_nxt      = ST_TURN;
                    last_owner_nxt = REQ_INTERP;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and round-robin history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_owner <= REQ_INTERP;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // A read access this cycle produces a one-cycle valid pulse when the RAM data arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= acc0 && !bus.wr0;
            rvalid1_q <= acc1 && !bus.wr1;
        end
    end

    mux_2_1 #(.WIDTH(ADDRESS_WIDTH)) u_mux_add1 (
        .a   (bus.add1_0),
        .b   (bus.add1_1),
        .sel (own1),
        .y   (sel_add1)
    );

    mux_2_1 #(.WIDTH(ADDRESS_WIDTH)) u_mux_add2 (
        .a   (bus.add2_0),
        .b   (bus.add2_1),
        .sel (own1),
        .y   (sel_add2)
    );

    mux_2_1 #(.WIDTH(WORD_SIZE)) u_mux_wdata (
        .a   (bus.wdata0),
        .b   (bus.wdata1),
        .sel (own1),
        .y   (sel_wdata)
    );

    mux_2_1 #(.WIDTH(1)) u_mux_wr (
        .a   (bus.wr0),
        .b   (bus.wr1),
        .sel (own1),
        .y   (sel_wr)
    );

    assign bus.ram_add1  = access ? sel_add1  : '0;
    assign bus.ram_add2  = access ? sel_add2  : '0;
    assign bus.ram_wdata = access ? sel_wdata : '0;
    assign bus.ram_we    = access && sel_wr;

    assign bus.gnt0    = own0;
    assign bus.gnt1    = own1;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata1  = bus.ram_data1;
    assign bus.rdata2  = bus.ram_data2;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural synchronous
// dual-port RAM. Unwritten RAM words read as 16'hA5xx where xx is the low
// address byte, so read data can be predicted by hand.
module tb_ram_port_arbiter;

    localparam int WS = 16;
    localparam int AW = 16;
    localparam int MH = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    bit   [255:0] wvalid;
    logic [15:0]  wmem [256];

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.WORD_SIZE(WS), .ADDRESS_WIDTH(AW)) bus ();

    ram_port_arbiter #(
        .WORD_SIZE     (WS),
        .ADDRESS_WIDTH (AW),
        .MAX_HOLD      (MH),
        .CNT_W         (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] mem_rd(input logic [7:0] a);
        return wvalid[a] ? wmem[a] : (16'hA500 | {8'h00, a});
    endfunction

    // RAM model: write through port 1, one-cycle read latency on both ports.
    always @(posedge clk) begin
        if (bus.ram_we) begin
            wmem[bus.ram_add1[7:0]]   <= bus.ram_wdata;
            wvalid[bus.ram_add1[7:0]] <= 1'b1;
        end
        bus.ram_data1 <= mem_rd(bus.ram_add1[7:0]);
        bus.ram_data2 <= mem_rd(bus.ram_add2[7:0]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0 = 0; bus.wr0 = 0; bus.add1_0 = '0; bus.add2_0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.wr1 = 0; bus.add1_1 = '0; bus.add2_1 = '0; bus.wdata1 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req0 = 1; bus.wr0 = 1; bus.add1_0 = 16'h1234; bus.wdata0 = 16'h5678; bus.req1 = 1;
        @(posedge clk);
        #3;
        vectors++; if (bus.gnt0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_gnt0: got %h want 0", bus.gnt0); end
        vectors++; if (bus.gnt1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_gnt1: got %h want 0", bus.gnt1); end
        vectors++; if (bus.rvalid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rvalid0: got %h want 0", bus.rvalid0); end
        vectors++; if (bus.rvalid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rvalid1: got %h want 0", bus.rvalid1); end
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ram_we: got %h want 0", bus.ram_we); end
        vectors++; if (bus.ram_add1 !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_ram_add1: got %h want 0000", bus.ram_add1); end
        vectors++; if (bus.ram_add2 !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_ram_add2: got %h want 0000", bus.ram_add2); end
        vectors++; if (bus.ram_wdata !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_ram_wdata: got %h want 0000", bus.ram_wdata); end
        vectors++; if (dut.u_hold.cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_hold_cnt: got %0d want 0", dut.u_hold.cnt); end
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        bus.req1 = 1; bus.wr1 = 0; bus.add1_1 = 16'h0004; bus.add2_1 = 16'h0201;
        #2;
        vectors++; if (bus.gnt1 !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_gnt1_early: got %h want 0", bus.gnt1); end
        tick(); #2;
        vectors++; if (bus.gnt1 !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_gnt1: got %h want 1", bus.gnt1); end
        vectors++; if (bus.gnt0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_gnt0: got %h want 0", bus.gnt0); end
        vectors++; if (bus.ram_add1 !== 16'h0004) begin miscompares++; $display("[TB] FAIL rd_ram_add1: got %h want 0004", bus.ram_add1); end
        vectors++; if (bus.ram_add2 !== 16'h0201) begin miscompares++; $display("[TB] FAIL rd_ram_add2: got %h want 0201", bus.ram_add2); end
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_ram_we: got %h want 0", bus.ram_we); end
        vectors++; if (bus.rvalid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_rvalid1_early: got %h want 0", bus.rvalid1); end
        tick(); bus.req1 = 0; #2;
        vectors++; if (bus.rvalid1 !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_rvalid1: got %h want 1", bus.rvalid1); end
        vectors++; if (bus.rdata1 !== 16'hA504) begin miscompares++; $display("[TB] FAIL rd_rdata1: got %h want a504", bus.rdata1); end
        vectors++; if (bus.rdata2 !== 16'hA501) begin miscompares++; $display("[TB] FAIL rd_rdata2: got %h want a501", bus.rdata2); end
        vectors++; if (bus.rvalid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_rvalid0: got %h want 0", bus.rvalid0); end
        vectors++; if (bus.ram_add1 !== 16'h0000) begin miscompares++; $display("[TB] FAIL rd_idle_add1: got %h want 0000", bus.ram_add1); end
        tick(); #2;
        vectors++; if (bus.gnt1 !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_turn_gnt1: got %h want 0", bus.gnt1); end
        vectors++; if (bus.rvalid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_turn_rvalid1: got %h want 0", bus.rvalid1); end
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        bus.req0 = 1; bus.req1 = 1; bus.add1_0 = 16'h0011; bus.add1_1 = 16'h0022;
        tick(); #2;
        vectors++; if (bus.gnt0 !== 1'b1) begin miscompares++; $display("[TB] FAIL tie_gnt0_first: got %h want 1", bus.gnt0); end
        vectors++; if (bus.gnt1 !== 1'b0) begin miscompares++; $display("[TB] FAIL tie_gnt1_first: got %h want 0", bus.gnt1); end
        vectors++; if (bus.ram_add1 !== 16'h0011) begin miscompares++; $display("[TB] FAIL tie_ram_add1_0: got %h want 0011", bus.ram_add1); end
        tick(); bus.req0 = 0; #2;
        vectors++; if (bus.rvalid0 !== 1'b1) begin miscompares++; $display("[TB] FAIL tie_rvalid0: got %h want 1", bus.rvalid0); end
        vectors++; if (bus.rdata1 !== 16'hA511) begin miscompares++; $display("[TB] FAIL tie_rdata1: got %h want a511", bus.rdata1); end
        vectors++; if (bus.ram_add1 !== 16'h0000) begin miscompares++; $display("[TB] FAIL tie_noreq_add1: got %h want 0000", bus.ram_add1); end
        tick(); #2;
        vectors++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin miscompares++; $display("[TB] FAIL tie_turn_gnt: got %b want 00", {bus.gnt0, bus.gnt1}); end
        tick(); #2;
        vectors++; if (bus.gnt1 !== 1'b1) begin miscompares++; $display("[TB] FAIL tie_gnt1_after_turn: got %h want 1", bus.gnt1); end
        vectors++; if (bus.ram_add1 !== 16'h0022) begin miscompares++; $display("[TB] FAIL tie_ram_add1_1: got %h want 0022", bus.ram_add1); end
        tick(); bus.req1 = 0; #2;
        vectors++; if (bus.rvalid1 !== 1'b1) begin miscompares++; $display("[TB] FAIL tie_rvalid1: got %h want 1", bus.rvalid1); end
        tick(); bus.req0 = 1; bus.req1 = 1; #2;
        vectors++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin miscompares++; $display("[TB] FAIL tie_turn2_gnt: got %b want 00", {bus.gnt0, bus.gnt1}); end
        tick(); #2;
        vectors++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin miscompares++; $display("[TB] FAIL tie_rr_gnt0: got %b want 10", {bus.gnt0, bus.gnt1}); end
        tick(); bus.req0 = 0; bus.req1 = 0;
        tick(); tick();
    endtask

    task automatic test_preempt_writes();
        int n_we   = 0;
        int n_turn = 0;
        bit seen0  = 0;
        bit got1   = 0;
        do_reset();
        bus.req0 = 1; bus.wr0 = 1; bus.add1_0 = 16'h0040; bus.wdata0 = 16'h0080;
        bus.req1 = 1; bus.wr1 = 0; bus.add1_1 = 16'h0050;
        for (int c = 0; c < 30 && !got1; c++) begin
            tick();
            bus.add1_0 = 16'h0040 + 16'(n_we);
            bus.wdata0 = 16'h0080 + 16'(n_we);
            #2;
            if (bus.gnt1) begin
                got1 = 1;
            end else if (bus.ram_we) begin
                vectors++; if (bus.ram_wdata !== 16'h0080 + 16'(n_we)) begin miscompares++; $display("[TB] FAIL pre_wdata[%0d]: got %h want %h", n_we, bus.ram_wdata, 16'h0080 + 16'(n_we)); end
                vectors++; if (bus.ram_add1 !== 16'h0040 + 16'(n_we)) begin miscompares++; $display("[TB] FAIL pre_add1[%0d]: got %h want %h", n_we, bus.ram_add1, 16'h0040 + 16'(n_we)); end
                n_we++;
            end else if (seen0 && !bus.gnt0) begin
                n_turn++;
            end
            if (bus.gnt0) seen0 = 1;
        end
        vectors++; if (got1 !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_gnt1_seen: got %0d want 1 within 30 cycles", got1); end
        vectors++; if (n_we !== 8) begin miscompares++; $display("[TB] FAIL pre_we_pulses: got %0d want 8", n_we); end
        vectors++; if (n_turn !== 1) begin miscompares++; $display("[TB] FAIL pre_turn_cycles: got %0d want 1", n_turn); end
        vectors++; if (mem_rd(8'h40) !== 16'h0080) begin miscompares++; $display("[TB] FAIL pre_mem40: got %h want 0080", mem_rd(8'h40)); end
        vectors++; if (mem_rd(8'h47) !== 16'h0087) begin miscompares++; $display("[TB] FAIL pre_mem47: got %h want 0087", mem_rd(8'h47)); end
        bus.wr0 = 0;
        #1;
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL pre_own1_we: got %h want 0", bus.ram_we); end
        vectors++; if (bus.ram_add1 !== 16'h0050) begin miscompares++; $display("[TB] FAIL pre_own1_add1: got %h want 0050", bus.ram_add1); end
        tick(); bus.req1 = 0;
        tick(); #2;
        vectors++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin miscompares++; $display("[TB] FAIL pre_turn2_gnt: got %b want 00", {bus.gnt0, bus.gnt1}); end
        tick(); #2;
        vectors++; if (bus.gnt0 !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_gnt0_back: got %h want 1", bus.gnt0); end
        tick(); bus.req0 = 0;
        tick(); tick();
    endtask

    task automatic test_saturate();
        int drops   = 0;
        int rv_miss = 0;
        do_reset();
        bus.req0 = 1; bus.wr0 = 0; bus.add1_0 = 16'h0003; bus.add2_0 = 16'h0005;
        tick();
        for (int i = 0; i < 20; i++) begin
            #2;
            if (!bus.gnt0) drops++;
            if (i > 0 && !bus.rvalid0) rv_miss++;
            tick();
        end
        #2;
        vectors++; if (drops !== 0) begin miscompares++; $display("[TB] FAIL sat_gnt0_drops: got %0d want 0", drops); end
        vectors++; if (rv_miss !== 0) begin miscompares++; $display("[TB] FAIL sat_rvalid_gaps: got %0d want 0", rv_miss); end
        vectors++; if (bus.gnt0 !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_gnt0_end: got %h want 1", bus.gnt0); end
        vectors++; if (dut.u_hold.cnt !== 4'd8) begin miscompares++; $display("[TB] FAIL sat_hold_cnt: got %0d want 8", dut.u_hold.cnt); end
        vectors++; if (bus.rdata2 !== 16'hA505) begin miscompares++; $display("[TB] FAIL sat_rdata2: got %h want a505", bus.rdata2); end
        tick(); bus.req0 = 0;
        tick(); tick();
    endtask

    task automatic test_last_read();
        int k = 0;
        bit seen0 = 0;
        bit turn_seen = 0;
        do_reset();
        bus.req0 = 1; bus.wr0 = 0; bus.add1_0 = 16'h0010; bus.add2_0 = 16'h0020;
        bus.req1 = 1; bus.wr1 = 0; bus.add1_1 = 16'h0060;
        for (int c = 0; c < 30 && !turn_seen; c++) begin
            tick();
            bus.add1_0 = 16'h0010 + 16'(k);
            bus.add2_0 = 16'h0020 + 16'(k);
            #2;
            if (bus.gnt0) begin
                seen0 = 1;
                k++;
            end else if (seen0) begin
                turn_seen = 1;
            end
        end
        vectors++; if (turn_seen !== 1'b1) begin miscompares++; $display("[TB] FAIL last_turn_seen: got %0d want 1 within 30 cycles", turn_seen); end
        vectors++; if (k !== 8) begin miscompares++; $display("[TB] FAIL last_accesses: got %0d want 8", k); end
        vectors++; if (bus.gnt1 !== 1'b0) begin miscompares++; $display("[TB] FAIL last_turn_gnt1: got %h want 0", bus.gnt1); end
        vectors++; if (bus.rvalid0 !== 1'b1) begin miscompares++; $display("[TB] FAIL last_rvalid0: got %h want 1", bus.rvalid0); end
        vectors++; if (bus.rvalid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL last_rvalid1: got %h want 0", bus.rvalid1); end
        vectors++; if (bus.rdata1 !== 16'hA517) begin miscompares++; $display("[TB] FAIL last_rdata1: got %h want a517", bus.rdata1); end
        vectors++; if (bus.rdata2 !== 16'hA527) begin miscompares++; $display("[TB] FAIL last_rdata2: got %h want a527", bus.rdata2); end
        tick(); #2;
        vectors++; if (bus.gnt1 !== 1'b1) begin miscompares++; $display("[TB] FAIL last_gnt1: got %h want 1", bus.gnt1); end
        vectors++; if (bus.rvalid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL last_rvalid0_off: got %h want 0", bus.rvalid0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req1 = 1; bus.wr1 = 0; bus.add1_1 = 16'h0030; bus.add2_1 = 16'h0031; bus.wdata1 = 16'h0BEE;
        tick(); #2;
        vectors++; if (bus.gnt1 !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_gnt1: got %h want 1", bus.gnt1); end
        tick(); bus.wr1 = 1; #1;
        vectors++; if (bus.rvalid1 !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_rvalid1_pre: got %h want 1", bus.rvalid1); end
        vectors++; if (bus.ram_we !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_we_pre: got %h want 1", bus.ram_we); end
        rst = 1'b0;
        #1;
        vectors++; if (bus.gnt1 !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_gnt1_rst: got %h want 0", bus.gnt1); end
        vectors++; if (bus.rvalid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_rvalid1_rst: got %h want 0", bus.rvalid1); end
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_we_rst: got %h want 0", bus.ram_we); end
        vectors++; if (bus.ram_add1 !== 16'h0000) begin miscompares++; $display("[TB] FAIL rmid_add1_rst: got %h want 0000", bus.ram_add1); end
        clear_inputs();
        bus.req0 = 1; bus.add1_0 = 16'h0001;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        vectors++; if (bus.gnt0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_gnt0_early: got %h want 0", bus.gnt0); end
        tick(); #2;
        vectors++; if (bus.gnt0 !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_gnt0: got %h want 1", bus.gnt0); end
        tick(); bus.req0 = 0;
        tick();
    endtask

    // Abort if the run stalls; the directed sequence is a few hundred cycles.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios in sequence, then the summary.
    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_preempt_writes();
        test_saturate();
        test_last_read();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
